gpio_button_link: RTL and testbench

Parametrised two-board button link for the multiplayer game.
- TX path: registers the local mouse button levels onto outgoing GPIO pins.
- RX path: for each incoming GPIO pin from the peer board, synchronises it, debounces it, and presents a clean level plus one-cycle rise/fall pulses to game logic.
- Loopback mode routes local buttons into the RX path for single-board self-test.
- Sits between the mouse controller, the board GPIO pins, and the game state logic.

---
 rtl/gpio_button_link.sv | 121 ++++++++++++
 tb/tb_gpio_button_link.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_button_link.sv
// gpio_button_link
//
// Two-board button link for the multiplayer game.
//   TX: registers local mouse button levels onto the outgoing GPIO pins.
//   RX: per channel, synchronises an incoming pin, debounces it and presents
//       a clean level plus one-cycle rise/fall pulses to the game logic.
//   Loopback feeds local_btn into the RX path so one board can test itself.
//
// Ports
//   clk           system clock (only clock)
//   rst           synchronous, active-high reset
//   local_btn     [CHANNELS] local button levels, already in the clk domain
//   loopback      1 = RX path samples local_btn instead of gpio_in
//   gpio_in       [CHANNELS] asynchronous pins from the peer board
//   gpio_out      [CHANNELS] registered copy of local_btn
//   remote_level  [CHANNELS] debounced remote level
//   remote_rise   [CHANNELS] one-cycle pulse on an accepted 0->1 change
//   remote_fall   [CHANNELS] one-cycle pulse on an accepted 1->0 change

module gpio_button_link #(
    parameter int unsigned CHANNELS        = 2,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] local_btn,
    input  logic                loopback,
    input  logic [CHANNELS-1:0] gpio_in,
    output logic [CHANNELS-1:0] gpio_out,
    output logic [CHANNELS-1:0] remote_level,
    output logic [CHANNELS-1:0] remote_rise,
    output logic [CHANNELS-1:0] remote_fall
);

    localparam int unsigned     CntW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    logic [CHANNELS-1:0] src;
    logic [CHANNELS-1:0] sync;
    logic [CHANNELS-1:0] sync_q [SYNC_STAGES];

    logic [CHANNELS-1:0] gpio_out_q;
    logic [CHANNELS-1:0] stable_q, stable_d;
    logic [CHANNELS-1:0] rise_q, rise_d;
    logic [CHANNELS-1:0] fall_q, fall_d;
    logic [CntW-1:0]     cnt_q [CHANNELS];
    logic [CntW-1:0]     cnt_d [CHANNELS];

    // Mux sits ahead of the synchroniser so loopback sees the identical filter.
    assign src  = loopback ? local_btn : gpio_in;
    assign sync = sync_q[SYNC_STAGES-1];

    // TX path
    always_ff @(posedge clk) begin
        if (rst) begin
            gpio_out_q <= '0;
        end else begin
            gpio_out_q <= local_btn;
        end
    end

    // Input synchroniser chain
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < int'(SYNC_STAGES); s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= src;
            for (int s = 1; s < int'(SYNC_STAGES); s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    // Debounce: a change is accepted only after DEBOUNCE_CYCLES consecutive
    // samples differ from the stable level; any agreeing sample restarts it.
    always_comb begin
        stable_d = stable_q;
        rise_d   = '0;
        fall_d   = '0;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CntMax) begin
                stable_d[i] = sync[i];
                cnt_d[i]    = '0;
                rise_d[i]   = sync[i];
                fall_d[i]   = ~sync[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stable_q <= '0;
            rise_q   <= '0;
            fall_q   <= '0;
            for (int i = 0; i < int'(CHANNELS); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            stable_q <= stable_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            for (int i = 0; i < int'(CHANNELS); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign gpio_out     = gpio_out_q;
    assign remote_level = stable_q;
    assign remote_rise  = rise_q;
    assign remote_fall  = fall_q;

endmodule

// File: tb/tb_gpio_button_link.sv
module tb_gpio_button_link;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] local_btn;
    logic       loopback;
    logic [1:0] gpio_in;
    logic [1:0] gpio_out;
    logic [1:0] remote_level;
    logic [1:0] remote_rise;
    logic [1:0] remote_fall;

    gpio_button_link #(
        .CHANNELS        (2),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .local_btn    (local_btn),
        .loopback     (loopback),
        .gpio_in      (gpio_in),
        .gpio_out     (gpio_out),
        .remote_level (remote_level),
        .remote_rise  (remote_rise),
        .remote_fall  (remote_fall)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned e;
        logic [5:0]  snap;  // {level, rise, fall}
    } exp_t;

    exp_t        sb[$];
    int unsigned edge_no = 0;
    int          rise_cnt[2];
    int          fall_cnt[2];
    int          total = 0;
    int          bad   = 0;
    int          r0, r1, f0, f1;

    // Edge counter and pulse tally; samples 1 time unit after each edge.
    initial begin
        rise_cnt = '{0, 0};
        fall_cnt = '{0, 0};
        forever begin
            @(posedge clk);
            edge_no = edge_no + 1;
            #1;
            for (int c = 0; c < 2; c++) begin
                if (remote_rise[c] === 1'b1) rise_cnt[c] = rise_cnt[c] + 1;
                if (remote_fall[c] === 1'b1) fall_cnt[c] = fall_cnt[c] + 1;
            end
        end
    end

    task automatic expect_at(input int unsigned e, input logic [1:0] lvl,
                             input logic [1:0] rise, input logic [1:0] fall);
        exp_t x;
        x.e    = e;
        x.snap = {lvl, rise, fall};
        sb.push_back(x);
    endtask

    task automatic snap_counts();
        r0 = rise_cnt[0]; r1 = rise_cnt[1];
        f0 = fall_cnt[0]; f1 = fall_cnt[1];
    endtask

    task automatic test_reset();
        int unsigned n;
        rst = 1'b1; loopback = 1'b0; gpio_in = 2'b11; local_btn = 2'b11;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if ({gpio_out, remote_level, remote_rise, remote_fall} !== 8'h00) begin
                bad++;
                $display("FAIL reset_hold cyc=%0d got=%b want=00000000", i,
                         {gpio_out, remote_level, remote_rise, remote_fall});
            end
        end
        snap_counts();
        rst = 1'b0; local_btn = 2'b00;
        n = edge_no;
        expect_at(n + 5, 2'b00, 2'b00, 2'b00);
        expect_at(n + 6, 2'b11, 2'b11, 2'b00);
        expect_at(n + 7, 2'b11, 2'b00, 2'b00);
        while (sb.size() != 0) begin
            @(negedge clk);
            if (edge_no >= sb[0].e) begin
                total++;
                if ({remote_level, remote_rise, remote_fall} !== sb[0].snap) begin
                    bad++;
                    $display("FAIL reset_release edge=%0d got=%b want=%b", edge_no,
                             {remote_level, remote_rise, remote_fall}, sb[0].snap);
                end
                sb.delete(0);
            end
        end
        gpio_in = 2'b00;
        n = edge_no;
        expect_at(n + 5, 2'b11, 2'b00, 2'b00);
        expect_at(n + 6, 2'b00, 2'b00, 2'b11);
        expect_at(n + 7, 2'b00, 2'b00, 2'b00);
        while (sb.size() != 0) begin
            @(negedge clk);
            if (edge_no >= sb[0].e) begin
                total++;
                if ({remote_level, remote_rise, remote_fall} !== sb[0].snap) begin
                    bad++;
                    $display("FAIL reset_fall edge=%0d got=%b want=%b", edge_no,
                             {remote_level, remote_rise, remote_fall}, sb[0].snap);
                end
                sb.delete(0);
            end
        end
        total++;
        if (rise_cnt[0] - r0 != 1 || rise_cnt[1] - r1 != 1 ||
            fall_cnt[0] - f0 != 1 || fall_cnt[1] - f1 != 1) begin
            bad++;
            $display("FAIL reset_pulse_count got r=%0d/%0d f=%0d/%0d want 1/1 1/1",
                     rise_cnt[0] - r0, rise_cnt[1] - r1, fall_cnt[0] - f0, fall_cnt[1] - f1);
        end
    endtask

    task automatic test_clean_rise();
        int unsigned n;
        snap_counts();
        @(negedge clk);
        gpio_in = 2'b01;
        n = edge_no;
        expect_at(n + 5, 2'b00, 2'b00, 2'b00);
        expect_at(n + 6, 2'b01, 2'b01, 2'b00);
        expect_at(n + 7, 2'b01, 2'b00, 2'b00);
        expect_at(n + 9, 2'b01, 2'b00, 2'b00);
        while (sb.size() != 0) begin
            @(negedge clk);
            if (edge_no >= sb[0].e) begin
                total++;
                if ({remote_level, remote_rise, remote_fall} !== sb[0].snap) begin
                    bad++;
                    $display("FAIL clean_rise edge=%0d got=%b want=%b", edge_no,
                             {remote_level, remote_rise, remote_fall}, sb[0].snap);
                end
                sb.delete(0);
            end
        end
        gpio_in = 2'b00;
        n = edge_no;
        expect_at(n + 5, 2'b01, 2'b00, 2'b00);
        expect_at(n + 6, 2'b00, 2'b00, 2'b01);
        expect_at(n + 7, 2'b00, 2'b00, 2'b00);
        while (sb.size() != 0) begin
            @(negedge clk);
            if (edge_no >= sb[0].e) begin
                total++;
                if ({remote_level, remote_rise, remote_fall} !== sb[0].snap) begin
                    bad++;
                    $display("FAIL clean_fall edge=%0d got=%b want=%b", edge_no,
                             {remote_level, remote_rise, remote_fall}, sb[0].snap);
                end
                sb.delete(0);
            end
        end
        total++;
        if (rise_cnt[0] - r0 != 1 || rise_cnt[1] - r1 != 0 ||
            fall_cnt[0] - f0 != 1 || fall_cnt[1] - f1 != 0) begin
            bad++;
            $display("FAIL clean_pulse_count got r=%0d/%0d f=%0d/%0d want 1/0 1/0",
                     rise_cnt[0] - r0, rise_cnt[1] - r1, fall_cnt[0] - f0, fall_cnt[1] - f1);
        end
    endtask

    task automatic test_glitch();
        int unsigned n;
        snap_counts();
        // Three samples high: must be discarded.
        @(negedge clk);
        gpio_in = 2'b10;
        repeat (3) @(negedge clk);
        gpio_in = 2'b00;
        n = edge_no;
        for (int unsigned e = n + 1; e <= n + 8; e++) expect_at(e, 2'b00, 2'b00, 2'b00);
        while (sb.size() != 0) begin
            @(negedge clk);
            if (edge_no >= sb[0].e) begin
                total++;
                if ({remote_level, remote_rise, remote_fall} !== sb[0].snap) begin
                    bad++;
                    $display("FAIL glitch3 edge=%0d got=%b want=%b", edge_no,
                             {remote_level, remote_rise, remote_fall}, sb[0].snap);
                end
                sb.delete(0);
            end
        end
        // Four samples high: accepted, then falls normally.
        gpio_in = 2'b10;
        n = edge_no;
        expect_at(n + 5, 2'b00, 2'b00, 2'b00);
        expect_at(n + 6, 2'b10, 2'b10, 2'b00);
        expect_at(n + 7, 2'b10, 2'b00, 2'b00);
        expect_at(n + 9, 2'b10, 2'b00, 2'b00);
        expect_at(n + 10, 2'b00, 2'b00, 2'b10);
        expect_at(n + 11, 2'b00, 2'b00, 2'b00);
        repeat (4) @(negedge clk);
        gpio_in = 2'b00;
        while (sb.size() != 0) begin
            @(negedge clk);
            if (edge_no >= sb[0].e) begin
                total++;
                if ({remote_level, remote_rise, remote_fall} !== sb[0].snap) begin
                    bad++;
                    $display("FAIL glitch4 edge=%0d got=%b want=%b", edge_no,
                             {remote_level, remote_rise, remote_fall}, sb[0].snap);
                end
                sb.delete(0);
            end
        end
        total++;
        if (rise_cnt[0] - r0 != 0 || rise_cnt[1] - r1 != 1 ||
            fall_cnt[0] - f0 != 0 || fall_cnt[1] - f1 != 1) begin
            bad++;
            $display("FAIL glitch_pulse_count got r=%0d/%0d f=%0d/%0d want 0/1 0/1",
                     rise_cnt[0] - r0, rise_cnt[1] - r1, fall_cnt[0] - f0, fall_cnt[1] - f1);
        end
    endtask

    task automatic test_tx();
        @(negedge clk);
        local_btn = 2'b10;
        total++;
        if (gpio_out !== 2'b00) begin
            bad++;
            $display("FAIL tx_before got=%b want=00", gpio_out);
        end
        @(negedge clk);
        total++;
        if (gpio_out !== 2'b10) begin
            bad++;
            $display("FAIL tx_latency got=%b want=10", gpio_out);
        end
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (gpio_out !== 2'b00) begin
            bad++;
            $display("FAIL tx_reset got=%b want=00", gpio_out);
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (gpio_out !== 2'b10) begin
            bad++;
            $display("FAIL tx_after_reset got=%b want=10", gpio_out);
        end
        local_btn = 2'b00;
        @(negedge clk);
        total++;
        if (gpio_out !== 2'b00 || remote_level !== 2'b00) begin
            bad++;
            $display("FAIL tx_clear got out=%b lvl=%b want 00 00", gpio_out, remote_level);
        end
    endtask

    task automatic test_loopback();
        int unsigned n;
        snap_counts();
        @(negedge clk);
        loopback = 1'b1; local_btn = 2'b01; gpio_in = 2'b10;
        n = edge_no;
        expect_at(n + 5, 2'b00, 2'b00, 2'b00);
        expect_at(n + 6, 2'b01, 2'b01, 2'b00);
        expect_at(n + 7, 2'b01, 2'b00, 2'b00);
        expect_at(n + 12, 2'b01, 2'b00, 2'b00);
        while (sb.size() != 0) begin
            @(negedge clk);
            if (edge_no >= sb[0].e) begin
                total++;
                if ({remote_level, remote_rise, remote_fall} !== sb[0].snap) begin
                    bad++;
                    $display("FAIL loopback_on edge=%0d got=%b want=%b", edge_no,
                             {remote_level, remote_rise, remote_fall}, sb[0].snap);
                end
                sb.delete(0);
            end
        end
        gpio_in = 2'b00;
        @(negedge clk);
        loopback = 1'b0;
        n = edge_no;
        expect_at(n + 5, 2'b01, 2'b00, 2'b00);
        expect_at(n + 6, 2'b00, 2'b00, 2'b01);
        expect_at(n + 7, 2'b00, 2'b00, 2'b00);
        while (sb.size() != 0) begin
            @(negedge clk);
            if (edge_no >= sb[0].e) begin
                total++;
                if ({remote_level, remote_rise, remote_fall} !== sb[0].snap) begin
                    bad++;
                    $display("FAIL loopback_off edge=%0d got=%b want=%b", edge_no,
                             {remote_level, remote_rise, remote_fall}, sb[0].snap);
                end
                sb.delete(0);
            end
        end
        local_btn = 2'b00;
        total++;
        if (rise_cnt[0] - r0 != 1 || rise_cnt[1] - r1 != 0 ||
            fall_cnt[0] - f0 != 1 || fall_cnt[1] - f1 != 0) begin
            bad++;
            $display("FAIL loopback_pulse_count got r=%0d/%0d f=%0d/%0d want 1/0 1/0",
                     rise_cnt[0] - r0, rise_cnt[1] - r1, fall_cnt[0] - f0, fall_cnt[1] - f1);
        end
    endtask

    task automatic test_reset_mid_count();
        int unsigned n;
        @(negedge clk);
        snap_counts();
        gpio_in = 2'b01;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total++;
        if ({remote_level, remote_rise, remote_fall} !== 6'b000000) begin
            bad++;
            $display("FAIL midcount_in_reset got=%b want=000000",
                     {remote_level, remote_rise, remote_fall});
        end
        rst = 1'b0;
        n = edge_no;
        expect_at(n + 5, 2'b00, 2'b00, 2'b00);
        expect_at(n + 6, 2'b01, 2'b01, 2'b00);
        expect_at(n + 7, 2'b01, 2'b00, 2'b00);
        while (sb.size() != 0) begin
            @(negedge clk);
            if (edge_no >= sb[0].e) begin
                total++;
                if ({remote_level, remote_rise, remote_fall} !== sb[0].snap) begin
                    bad++;
                    $display("FAIL midcount_rise edge=%0d got=%b want=%b", edge_no,
                             {remote_level, remote_rise, remote_fall}, sb[0].snap);
                end
                sb.delete(0);
            end
        end
        total++;
        if (rise_cnt[0] - r0 != 1 || rise_cnt[1] - r1 != 0 ||
            fall_cnt[0] - f0 != 0 || fall_cnt[1] - f1 != 0) begin
            bad++;
            $display("FAIL midcount_pulse_count got r=%0d/%0d f=%0d/%0d want 1/0 0/0",
                     rise_cnt[0] - r0, rise_cnt[1] - r1, fall_cnt[0] - f0, fall_cnt[1] - f1);
        end
        gpio_in = 2'b00;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_clean_rise();
        test_glitch();
        test_tx();
        test_loopback();
        test_reset_mid_count();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #50000;
        $display("FAIL timeout edge=%0d got=running want=finished", edge_no);
        $fatal(1, "timeout");
    end

endmodule
